// File: rtl/fltadd_pkg.sv
// Shared types and memory map for the float-add scheduler: FSM states,
// the data-memory byte addresses of the engine mailbox, and the timeout result.
package fltadd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    START,
    WAIT,
    READ,
    RESP
  } state_t;

  localparam logic [7:0] OPA_HI = 8'd128;
  localparam logic [7:0] OPA_LO = 8'd129;
  localparam logic [7:0] OPB_HI = 8'd130;
  localparam logic [7:0] OPB_LO = 8'd131;
  localparam logic [7:0] RES_HI = 8'd132;
  localparam logic [7:0] RES_LO = 8'd133;

  localparam logic [15:0] ERR_RESULT = 16'hFFFF;

  // Operand byte order in the mailbox: A high, A low, B high, B low.
  function automatic logic [7:0] write_addr(input logic [1:0] bcnt);
    case (bcnt)
      2'd0:    return OPA_HI;
      2'd1:    return OPA_LO;
      2'd2:    return OPB_HI;
      default: return OPB_LO;
    endcase
  endfunction

  function automatic logic [7:0] write_byte(input logic [15:0] a, input logic [15:0] b,
                                            input logic [1:0] bcnt);
    case (bcnt)
      2'd0:    return a[15:8];
      2'd1:    return a[7:0];
      2'd2:    return b[15:8];
      default: return b[7:0];
    endcase
  endfunction

endpackage

// File: rtl/fltadd_sched_arb.sv
// Combinational round-robin arbiter: searches from last+1 upward with wrap,
// skipping masked requesters, and returns a one-hot grant plus a valid bit.
module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  mask,
  input  logic [IDX_W-1:0] last,
  output logic [NREQ-1:0]  grant,
  output logic             valid
);

  logic [NREQ-1:0]  eligible;
  logic [IDX_W-1:0] idx;

  // NOTE: every variable written here gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    eligible = req & ~mask;
    grant    = '0;
    valid    = 1'b0;
    idx      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDX_W'((int'(last) + k) % NREQ);
      if (!valid && eligible[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fltadd_sched.sv
// Shares one float-add engine among NREQ requesters: round-robin grant,
// operand write to the mailbox, start/done handshake with timeout, readback, ack.
module fltadd_sched
  import fltadd_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0][15:0] opa,
  input  logic [NREQ-1:0][15:0] opb,
  output logic [NREQ-1:0]       ack,
  output logic [15:0]           result,
  output logic                  err,
  output logic                  busy,
  output logic [7:0]            mem_addr,
  output logic                  mem_wr,
  output logic                  mem_rd,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata,
  output logic                  eng_start,
  input  logic                  eng_done
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] gidx_q, gidx_d, last_q, last_d, win_idx;
  logic [NREQ-1:0]  mask_q, mask_d, grant, gidx_oh;
  logic             grant_valid;
  logic [15:0]      opa_q, opa_d, opb_q, opb_d;
  logic [1:0]       bcnt_q, bcnt_d, rcnt_q, rcnt_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic [7:0]       res_hi_q, res_hi_d;

  logic [NREQ-1:0]  ack_d;
  logic [15:0]      result_d;
  logic             err_d, busy_d, mem_wr_d, mem_rd_d, eng_start_d;
  logic [7:0]       mem_addr_d, mem_wdata_d;

  rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
    .req   (req),
    .mask  (mask_q),
    .last  (last_q),
    .grant (grant),
    .valid (grant_valid)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) win_idx = IDX_W'(i);
    end
  end

  assign gidx_oh = NREQ'(1) << gidx_q;

  // Next state and counters first; the registered outputs are then decoded
  // from the next state so every strobe lines up with the state it belongs to.
  always_comb begin
    state_d  = state_q;
    gidx_d   = gidx_q;
    last_d   = last_q;
    mask_d   = '0;
    opa_d    = opa_q;
    opb_d    = opb_q;
    bcnt_d   = bcnt_q;
    rcnt_d   = rcnt_q;
    tcnt_d   = tcnt_q;
    res_hi_d = res_hi_q;
    result_d = '0;
    err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          gidx_d  = win_idx;
          opa_d   = opa[win_idx];
          opb_d   = opb[win_idx];
          bcnt_d  = '0;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (bcnt_q == 2'd3) state_d = START;
        else                bcnt_d  = bcnt_q + 2'd1;
      end
      START: begin
        tcnt_d  = '0;
        rcnt_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (eng_done) begin
          state_d = READ;
        end else if (tcnt_q == TCNT_LAST) begin
          result_d = ERR_RESULT;
          err_d    = 1'b1;
          state_d  = RESP;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      READ: begin
        // Read data trails the strobe by one cycle.
        if (rcnt_q == 2'd1) res_hi_d = mem_rdata;
        if (rcnt_q == 2'd2) begin
          result_d = {res_hi_q, mem_rdata};
          state_d  = RESP;
        end else begin
          rcnt_d = rcnt_q + 2'd1;
        end
      end
      RESP: begin
        last_d  = gidx_q;
        mask_d  = gidx_oh;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    ack_d       = '0;
    mem_wr_d    = 1'b0;
    mem_rd_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    eng_start_d = 1'b0;
    busy_d      = (state_d != IDLE);

    case (state_d)
      WRITE: begin
        mem_wr_d    = 1'b1;
        mem_addr_d  = write_addr(bcnt_d);
        mem_wdata_d = write_byte(opa_d, opb_d, bcnt_d);
      end
      START: eng_start_d = 1'b1;
      READ: begin
        if (rcnt_d == 2'd0) begin
          mem_rd_d   = 1'b1;
          mem_addr_d = RES_HI;
        end else if (rcnt_d == 2'd1) begin
          mem_rd_d   = 1'b1;
          mem_addr_d = RES_LO;
        end
      end
      RESP:    ack_d = gidx_oh;
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      gidx_q    <= '0;
      last_q    <= IDX_W'(NREQ - 1);
      mask_q    <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      bcnt_q    <= '0;
      rcnt_q    <= '0;
      tcnt_q    <= '0;
      res_hi_q  <= '0;
      ack       <= '0;
      result    <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
      mem_addr  <= '0;
      mem_wr    <= 1'b0;
      mem_rd    <= 1'b0;
      mem_wdata <= '0;
      eng_start <= 1'b0;
    end else begin
      state_q   <= state_d;
      gidx_q    <= gidx_d;
      last_q    <= last_d;
      mask_q    <= mask_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      bcnt_q    <= bcnt_d;
      rcnt_q    <= rcnt_d;
      tcnt_q    <= tcnt_d;
      res_hi_q  <= res_hi_d;
      ack       <= ack_d;
      result    <= result_d;
      err       <= err_d;
      busy      <= busy_d;
      mem_addr  <= mem_addr_d;
      mem_wr    <= mem_wr_d;
      mem_rd    <= mem_rd_d;
      mem_wdata <= mem_wdata_d;
      eng_start <= eng_start_d;
    end
  end

endmodule

// File: tb/tb_fltadd_sched.sv
// Scoreboard bench for fltadd_sched with a data-memory and float-add engine model;
// expected writes and acks are queued at issue time and popped by monitors.
module tb_fltadd_sched;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 64;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0][15:0] opa, opb;
  logic [NREQ-1:0]       ack;
  logic [15:0]           result;
  logic                  err, busy, mem_wr, mem_rd, eng_start;
  logic [7:0]            mem_addr, mem_wdata;
  logic [7:0]            mem_rdata = 8'h00;
  logic                  eng_done  = 1'b0;

  always #5 clk = ~clk;

  fltadd_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .opa       (opa),
    .opb       (opb),
    .ack       (ack),
    .result    (result),
    .err       (err),
    .busy      (busy),
    .mem_addr  (mem_addr),
    .mem_wr    (mem_wr),
    .mem_rd    (mem_rd),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .eng_start (eng_start),
    .eng_done  (eng_done)
  );

  int n_vec = 0, n_fail = 0, cyc = 0, n_reads = 0, n_starts = 0;

  typedef struct packed {
    logic [NREQ-1:0] ack;
    logic [15:0]     result;
    logic            err;
  } resp_t;

  resp_t       exp_q[$];
  logic [15:0] wr_q[$];
  int          ack_t[$], wr0_t[$];
  logic [NREQ-1:0] hold = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Engine model: hand-computed half-precision sums for the directed vectors.
  function automatic logic [15:0] fadd_ref(input logic [15:0] a, input logic [15:0] b);
    case ({a, b})
      32'h3C00_3C00: return 16'h4000;
      32'h4000_3C00: return 16'h4200;
      32'h3800_3800: return 16'h3C00;
      32'h4400_4400: return 16'h4800;
      32'h4200_3C00: return 16'h4400;
      32'h3C00_BC00: return 16'h0000;
      default:       return 16'hDEAD;
    endcase
  endfunction

  logic [7:0]  mem [256];
  logic [15:0] eng_sum;
  int          eng_lat  = 2;
  bit          eng_hang = 1'b0;
  bit          eng_busy = 1'b0;
  int          eng_cnt  = 0;

  assign eng_sum = fadd_ref({mem[128], mem[129]}, {mem[130], mem[131]});

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_wr) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem_rd ? mem[mem_addr] : 8'h00;
    if (eng_start) begin
      eng_done <= 1'b0;
      eng_cnt  <= eng_lat;
      eng_busy <= !eng_hang;
    end else if (eng_busy) begin
      if (eng_cnt == 0) begin
        mem[132] <= eng_sum[15:8];
        mem[133] <= eng_sum[7:0];
        eng_done <= 1'b1;
        eng_busy <= 1'b0;
      end else begin
        eng_cnt <= eng_cnt - 1;
      end
    end
  end

  task automatic mon_write();
    if (mem_addr == 8'd128) wr0_t.push_back(cyc);
    if (wr_q.size() == 0) check("write_unexpected", {16'h0, mem_addr, mem_wdata}, 32'hFFFF_FFFF);
    else                  check("write", {16'h0, mem_addr, mem_wdata}, {16'h0, wr_q.pop_front()});
  endtask

  task automatic mon_ack();
    resp_t e;
    ack_t.push_back(cyc);
    if (exp_q.size() == 0) begin
      check("ack_unexpected", ack, 0);
    end else begin
      e = exp_q.pop_front();
      check("ack", ack, e.ack);
      check("result", result, e.result);
      check("err", err, e.err);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (mem_wr || mem_rd) check("strobe_excl", {31'h0, mem_wr & mem_rd}, 0);
      if (mem_rd) n_reads <= n_reads + 1;
      if (eng_start) n_starts <= n_starts + 1;
      if (mem_wr) mon_write();
      if (ack != '0) mon_ack();
    end
  end

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
    opa[i] = a;
    opb[i] = b;
    req[i] = 1'b1;
  endtask

  task automatic expect_writes(input logic [15:0] a, input logic [15:0] b);
    wr_q.push_back({8'd128, a[15:8]});
    wr_q.push_back({8'd129, a[7:0]});
    wr_q.push_back({8'd130, b[15:8]});
    wr_q.push_back({8'd131, b[7:0]});
  endtask

  task automatic expect_op(input int i, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] sum, input logic e);
    resp_t r;
    expect_writes(a, b);
    r.ack    = NREQ'(1) << i;
    r.result = sum;
    r.err    = e;
    exp_q.push_back(r);
  endtask

  task automatic clear_times();
    ack_t.delete();
    wr0_t.delete();
  endtask

  // Drops each req on its ack (or consumes one hold credit), bounded by budget.
  task automatic drain(input int budget);
    int n = 0;
    while (req != '0 && n < budget) begin
      @(negedge clk);
      n++;
      for (int i = 0; i < NREQ; i++) begin
        if (ack[i]) begin
          if (hold[i]) hold[i] = 1'b0;
          else         req[i]  = 1'b0;
        end
      end
    end
    if (req != '0) check("drain_timeout", req, 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"},       ack, 0);
    check({tag, "_result"},    result, 0);
    check({tag, "_err"},       err, 0);
    check({tag, "_busy"},      busy, 0);
    check({tag, "_mem_wr"},    mem_wr, 0);
    check({tag, "_mem_rd"},    mem_rd, 0);
    check({tag, "_mem_addr"},  mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_eng_start"}, eng_start, 0);
  endtask

  initial begin
    int s0, r0, n;
    reset = 1'b0;
    req   = '0;
    opa   = '0;
    opb   = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b1;
    @(negedge clk);

    // All four at once: order 0,1,2,3, one op every 14 cycles with engine latency 2.
    clear_times();
    set_req(0, 16'h3C00, 16'h3C00); expect_op(0, 16'h3C00, 16'h3C00, 16'h4000, 1'b0);
    set_req(1, 16'h4000, 16'h3C00); expect_op(1, 16'h4000, 16'h3C00, 16'h4200, 1'b0);
    set_req(2, 16'h3800, 16'h3800); expect_op(2, 16'h3800, 16'h3800, 16'h3C00, 1'b0);
    set_req(3, 16'h4400, 16'h4400); expect_op(3, 16'h4400, 16'h4400, 16'h4800, 1'b0);
    drain(200);
    check("all4_latency", ack_t[0] - wr0_t[0], 12);
    for (int k = 0; k < 3; k++) check("all4_spacing", ack_t[k+1] - ack_t[k], 14);

    // Requester 0 alone: 1.0 + 1.0.
    clear_times();
    s0 = n_starts;
    set_req(0, 16'h3C00, 16'h3C00); expect_op(0, 16'h3C00, 16'h3C00, 16'h4000, 1'b0);
    drain(100);
    check("single_latency", ack_t[0] - wr0_t[0], 12);
    check("single_starts", n_starts - s0, 1);

    // Requester 2 holds req through its ack: re-grant waits out the masked cycle.
    clear_times();
    hold = 4'b0100;
    set_req(2, 16'h4200, 16'h3C00);
    expect_op(2, 16'h4200, 16'h3C00, 16'h4400, 1'b0);
    expect_op(2, 16'h4200, 16'h3C00, 16'h4400, 1'b0);
    drain(200);
    check("regrant_gap", wr0_t[1] - ack_t[0], 3);
    check("regrant_latency", ack_t[1] - wr0_t[1], 12);

    // done still high from the previous op; engine latency 5 must show in full.
    clear_times();
    eng_lat = 5;
    set_req(0, 16'h3C00, 16'hBC00); expect_op(0, 16'h3C00, 16'hBC00, 16'h0000, 1'b0);
    drain(100);
    check("stale_done_latency", ack_t[0] - wr0_t[0], 15);
    eng_lat = 2;

    // Engine never finishes: ack TIMEOUT+6 after grant, error result, no readback.
    clear_times();
    eng_hang = 1'b1;
    r0 = n_reads;
    set_req(1, 16'h4000, 16'h4000); expect_op(1, 16'h4000, 16'h4000, 16'hFFFF, 1'b1);
    drain(300);
    check("timeout_latency", ack_t[0] - wr0_t[0], TIMEOUT + 5);
    check("timeout_no_reads", n_reads - r0, 0);

    // Reset during WAIT: requester 3 is in flight (last=1), 1 and 3 pending.
    s0 = n_starts;
    opa[1] = 16'h3800; opb[1] = 16'h3800;
    opa[3] = 16'h4000; opb[3] = 16'h3C00;
    req = 4'b1010;
    expect_writes(16'h4000, 16'h3C00);
    n = 0;
    while (n_starts == s0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("reset_test_started", n_starts - s0, 1);
    repeat (3) @(posedge clk);
    #1;
    check("busy_in_wait", busy, 1);
    #1 reset = 1'b0;
    #1 check_reset_outputs("abort");
    check("writes_before_abort", wr_q.size(), 0);
    eng_hang = 1'b0;
    repeat (2) @(negedge clk);
    expect_op(1, 16'h3800, 16'h3800, 16'h3C00, 1'b0);
    expect_op(3, 16'h4000, 16'h3C00, 16'h4200, 1'b0);
    reset = 1'b1;
    drain(200);

    check("exp_q_empty", exp_q.size(), 0);
    check("wr_q_empty", wr_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
    $fatal(1);
  end

endmodule
